// File: rtl/fcmp_arbiter.sv
// -----------------------------------------------------------------------------
// fcmp_arbiter
//
// Two-requester round-robin arbiter in front of a single-precision compare
// unit. One request is accepted per transaction; the compare result is
// captured at the grant edge and held until the consumer takes it.
//
// Ports
//   clk         rising-edge clock
//   rstn        asynchronous active-low reset
//   req_valid   per-requester request valid (bit i = requester i)
//   req_ready   per-requester accept strobe (combinational, IDLE only)
//   req_op      {op1,op0}, 2 bits each: 00 FEQ, 01 FLT, 10 FLE, 11 reserved
//   req_x       {x1,x0} 32-bit single-precision operands
//   req_y       {y1,y0} 32-bit single-precision operands
//   resp_valid  result valid
//   resp_id     index of the requester owning the result
//   resp_res    {31'b0, flag}
//   resp_ready  consumer accepts the result
// -----------------------------------------------------------------------------
module fcmp_arbiter #(
  parameter int N_REQ = 2  // only 2 is supported
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [2*N_REQ-1:0]   req_op,
  input  logic [32*N_REQ-1:0]  req_x,
  input  logic [32*N_REQ-1:0]  req_y,
  output logic                 resp_valid,
  output logic                 resp_id,
  output logic [31:0]          resp_res,
  input  logic                 resp_ready
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  localparam logic [1:0] OP_FEQ = 2'b00;
  localparam logic [1:0] OP_FLT = 2'b01;
  localparam logic [1:0] OP_FLE = 2'b10;

  // ---------------------------------------------------------------------------
  // Compare helpers. Operands are treated as sign-magnitude integers; NaN and
  // Inf are not special-cased. Both zero encodings compare equal.
  // ---------------------------------------------------------------------------
  function automatic logic is_zero(input logic [31:0] a);
    return (a[30:0] == 31'd0);
  endfunction

  function automatic logic fp_eq(input logic [31:0] a, input logic [31:0] b);
    return (a == b) || (is_zero(a) && is_zero(b));
  endfunction

  function automatic logic fp_lt(input logic [31:0] a, input logic [31:0] b);
    logic lt;
    if (is_zero(a) && is_zero(b)) begin
      lt = 1'b0;
    end else if (a[31] != b[31]) begin
      // Signs differ: the negative operand is the smaller one.
      lt = a[31];
    end else if (a[31] == 1'b0) begin
      lt = (a[30:0] < b[30:0]);
    end else begin
      // Both negative: larger magnitude is the smaller value.
      lt = (a[30:0] > b[30:0]);
    end
    return lt;
  endfunction

  function automatic logic fcmp_flag(input logic [1:0] op,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
    logic f;
    case (op)
      OP_FEQ:  f = fp_eq(a, b);
      OP_FLT:  f = fp_lt(a, b);
      OP_FLE:  f = fp_lt(a, b) | fp_eq(a, b);
      default: f = 1'b0;  // reserved op
    endcase
    return f;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [0:0] state_q, state_d;
  logic       ptr_q, ptr_d;
  logic       resp_valid_q, resp_valid_d;
  logic       resp_id_q, resp_id_d;
  logic       flag_q, flag_d;

  logic       grant_any_s;
  logic       grant_idx_s;
  logic [1:0] sel_op_s;
  logic [31:0] sel_x_s;
  logic [31:0] sel_y_s;
  logic       cmp_flag_s;

  // Arbitration: pointer wins only on contention, a lone requester always wins.
  always_comb begin
    grant_any_s = 1'b0;
    grant_idx_s = 1'b0;
    if (state_q == ST_IDLE) begin
      grant_any_s = |req_valid;
      if (&req_valid) begin
        grant_idx_s = ptr_q;
      end else if (req_valid[1]) begin
        grant_idx_s = 1'b1;
      end else begin
        grant_idx_s = 1'b0;
      end
    end else begin
      grant_any_s = 1'b0;
      grant_idx_s = 1'b0;
    end
  end

  // Accept strobe; gated by rstn so it is low throughout reset.
  always_comb begin
    req_ready = {N_REQ{1'b0}};
    if (rstn && grant_any_s) begin
      req_ready[grant_idx_s] = 1'b1;
    end else begin
      req_ready = {N_REQ{1'b0}};
    end
  end

  // Operand mux: only the granted requester's op/x/y reach the comparator.
  always_comb begin
    if (grant_idx_s) begin
      sel_op_s = req_op[3:2];
      sel_x_s  = req_x[63:32];
      sel_y_s  = req_y[63:32];
    end else begin
      sel_op_s = req_op[1:0];
      sel_x_s  = req_x[31:0];
      sel_y_s  = req_y[31:0];
    end
    cmp_flag_s = fcmp_flag(sel_op_s, sel_x_s, sel_y_s);
  end

  // Next-state: grant in IDLE, hold in RESP until the response handshake.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    flag_d       = flag_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_any_s) begin
          state_d      = ST_RESP;
          ptr_d        = ~grant_idx_s;
          resp_valid_d = 1'b1;
          resp_id_d    = grant_idx_s;
          flag_d       = cmp_flag_s;
        end else begin
          state_d      = ST_IDLE;
        end
      end
      ST_RESP: begin
        // The completion edge returns to IDLE without granting; the
        // earliest next grant is the following cycle.
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
        end else begin
          state_d      = ST_RESP;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  // State registers; reset discards any pending result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      ptr_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      flag_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      flag_q       <= flag_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_res   = {31'd0, flag_q};

endmodule

// File: tb/tb_fcmp_arbiter.sv
module tb_fcmp_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [3:0]  req_op = 4'h0;
  logic [63:0] req_x = 64'd0;
  logic [63:0] req_y = 64'd0;
  logic        resp_valid;
  logic        resp_id;
  logic [31:0] resp_res;
  logic        resp_ready = 1'b0;

  fcmp_arbiter #(.N_REQ(2)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_x(req_x), .req_y(req_y),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_res(resp_res),
    .resp_ready(resp_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state (transaction level).
  bit m_busy = 1'b0;
  bit m_ptr  = 1'b0;
  bit m_id   = 1'b0;
  bit m_flag = 1'b0;
  int cyc    = 0;
  int grant_q[$];
  int gcyc_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Map a sign-magnitude float pattern onto a signed integer line; both zeros -> 0.
  function automatic longint fkey(input logic [31:0] a);
    longint m;
    m = longint'(a[30:0]);
    return a[31] ? -m : m;
  endfunction

  function automatic logic ref_flag(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint ka, kb;
    ka = fkey(a);
    kb = fkey(b);
    case (op)
      2'b00:   return ka == kb;
      2'b01:   return ka < kb;
      2'b10:   return ka <= kb;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    case ($urandom_range(0, 5))
      0: r = 32'h0000_0000;
      1: r = 32'h8000_0000;
      2: r = {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 8'h7F, 23'd0};
      3: r = {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 31'($urandom_range(0, 7))};
      default: r = $urandom;
    endcase
    return r;
  endfunction

  // One clock: drive at negedge, check after settling, update model at posedge.
  task automatic step(input logic [1:0] v, input logic [3:0] op, input logic [63:0] x,
                      input logic [63:0] y, input logic rr);
    logic [1:0] exp_rdy;
    logic       g;
    req_valid = v; req_op = op; req_x = x; req_y = y; resp_ready = rr;
    exp_rdy = 2'b00;
    g = 1'b0;
    if (!m_busy && v != 2'b00) begin
      g = (v == 2'b11) ? m_ptr : v[1];
      exp_rdy = g ? 2'b10 : 2'b01;
    end
    #1;
    chk("req_ready", {30'd0, req_ready}, {30'd0, exp_rdy});
    chk("resp_valid", {31'd0, resp_valid}, {31'd0, m_busy});
    if (m_busy) begin
      chk("resp_id", {31'd0, resp_id}, {31'd0, m_id});
      chk("resp_res", resp_res, {31'd0, m_flag});
    end
    chk("res_hi", {1'b0, resp_res[31:1]}, 32'd0);
    @(posedge clk);
    if (m_busy) begin
      if (rr) m_busy = 1'b0;
    end else if (v != 2'b00) begin
      m_busy = 1'b1;
      m_id   = g;
      m_flag = g ? ref_flag(op[3:2], x[63:32], y[63:32]) : ref_flag(op[1:0], x[31:0], y[31:0]);
      m_ptr  = ~g;
      grant_q.push_back(int'(g));
      gcyc_q.push_back(cyc);
    end
    cyc++;
    @(negedge clk);
  endtask

  // Single requester-0 transaction with an explicit expected result.
  task automatic op1(input string tag, input logic [1:0] op, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] exp);
    step(2'b01, {2'b00, op}, {32'd0, x}, {32'd0, y}, 1'b1);
    chk({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, "_id"}, {31'd0, resp_id}, 32'd0);
    chk(tag, resp_res, exp);
    step(2'b00, 4'h0, 64'd0, 64'd0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] held_res;
    logic        held_id;
    // Reset state with both requesters asserting.
    req_valid = 2'b11;
    #12;
    chk("rst_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_id", {31'd0, resp_id}, 32'd0);
    chk("rst_res", resp_res, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Contention: alternating grants, one per two cycles, first to requester 0.
    grant_q.delete();
    gcyc_q.delete();
    for (int i = 0; i < 16; i++)
      step(2'b11, 4'($urandom), {rand_fp(), rand_fp()}, {rand_fp(), rand_fp()}, 1'b1);
    chk("rr_count", 32'(grant_q.size()), 32'd8);
    for (int i = 0; i < grant_q.size(); i++) begin
      chk("rr_order", 32'(grant_q[i]), 32'(i % 2));
      if (i > 0) chk("rr_spacing", 32'(gcyc_q[i] - gcyc_q[i-1]), 32'd2);
    end

    // Directed compare cases.
    op1("flt_1_2",    2'b01, 32'h3F80_0000, 32'h4000_0000, 32'd1);
    op1("flt_m1_1",   2'b01, 32'hBF80_0000, 32'h3F80_0000, 32'd1);
    op1("flt_m2_m1",  2'b01, 32'hC000_0000, 32'hBF80_0000, 32'd1);
    op1("feq_zeros",  2'b00, 32'h8000_0000, 32'h0000_0000, 32'd1);
    op1("flt_zeros",  2'b01, 32'h8000_0000, 32'h0000_0000, 32'd0);
    op1("fle_eq",     2'b10, 32'h3F80_0000, 32'h3F80_0000, 32'd1);
    op1("flt_m1_m2",  2'b01, 32'hBF80_0000, 32'hC000_0000, 32'd0);
    op1("rsv_eq",     2'b11, 32'h3F80_0000, 32'h3F80_0000, 32'd0);
    op1("rsv_rand",   2'b11, $urandom, $urandom, 32'd0);

    // Backpressure: outputs hold and no acceptance while the result waits.
    step(2'b11, 4'b0101, {32'h4000_0000, 32'h3F80_0000}, {32'h3F80_0000, 32'h4000_0000}, 1'b0);
    held_res = resp_res;
    held_id  = resp_id;
    for (int i = 0; i < 5; i++) begin
      step(2'b11, 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
      chk("bp_res_hold", resp_res, held_res);
      chk("bp_id_hold", {31'd0, resp_id}, {31'd0, held_id});
    end
    step(2'b11, 4'h5, 64'd0, 64'd1, 1'b1);
    chk("bp_idle_after", {31'd0, resp_valid}, 32'd0);
    step(2'b11, 4'h5, 64'd0, 64'd1, 1'b0);
    chk("bp_regrant", {31'd0, resp_valid}, 32'd1);

    // Asynchronous reset while a result is pending.
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_valid", {31'd0, resp_valid}, 32'd0);
    chk("arst_ready", {30'd0, req_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    m_busy = 1'b0;
    m_ptr  = 1'b0;
    step(2'b11, 4'h1, {rand_fp(), rand_fp()}, {rand_fp(), rand_fp()}, 1'b1);
    chk("arst_first_grant", 32'(grant_q[grant_q.size()-1]), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] x0, x1, y0, y1;
      x0 = rand_fp(); x1 = rand_fp();
      y0 = ($urandom_range(0, 3) == 0) ? x0 : rand_fp();
      y1 = ($urandom_range(0, 3) == 0) ? x1 : rand_fp();
      step(2'($urandom), 4'($urandom), {x1, x0}, {y1, y0}, ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
    end
    step(2'b00, 4'h0, 64'd0, 64'd0, 1'b1);
    step(2'b00, 4'h0, 64'd0, 64'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
